// File: rtl/mac_accum_pkg.sv
// Shared types and default sizing for the sequential multiply-accumulate stage.
package mac_accum_pkg;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_DONE  = 1'b1
    } state_e;

    localparam int DEF_WIDTH     = 4;
    localparam int DEF_NUM_TERMS = 4;

endpackage

// File: rtl/mac_comb_cell.sv
// Combinational MAC cell: sum = (a*b + c) mod 2^WIDTH, ovf flags any dropped upper bits.
module mac_comb_cell
    import mac_accum_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] sum,
    output logic             ovf
);

    localparam int FW = 2 * WIDTH + 1;

    logic [FW-1:0] full;

    always_comb begin
        full = FW'(a) * FW'(b) + FW'(c);
        sum  = full[WIDTH-1:0];
        ovf  = |full[FW-1:WIDTH];
    end

endmodule

// File: rtl/mac_accum_seq.sv
// Frame-based multiply-accumulate stage with valid/ready result port.
// Define MAC_ACCUM_OVF_EN to add the sticky-overflow output out_ovf.
module mac_accum_seq
    import mac_accum_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int NUM_TERMS = DEF_NUM_TERMS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef MAC_ACCUM_OVF_EN
    ,
    output logic             out_ovf
`endif
);

    localparam int CNT_W = $clog2(NUM_TERMS + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_TERMS - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [WIDTH-1:0] mac_sum;
    logic             mac_ovf;
    logic             accept;

`ifdef MAC_ACCUM_OVF_EN
    logic sticky_q, sticky_d;
    logic out_ovf_q, out_ovf_d;
`else
    logic unused_ovf;
    assign unused_ovf = mac_ovf;
`endif

    mac_comb_cell #(
        .WIDTH(WIDTH)
    ) u_cell (
        .a  (in_a),
        .b  (in_b),
        .c  (acc_q),
        .sum(mac_sum),
        .ovf(mac_ovf)
    );

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
`ifdef MAC_ACCUM_OVF_EN
        sticky_d    = sticky_q;
        out_ovf_d   = out_ovf_q;
`endif
        in_ready    = (state_q == ST_ACCUM) && !acc_clr;
        accept      = in_valid && in_ready;

        unique case (state_q)
            ST_ACCUM: begin
                if (acc_clr) begin
                    acc_d = '0;
                    cnt_d = '0;
`ifdef MAC_ACCUM_OVF_EN
                    sticky_d = 1'b0;
`endif
                end else if (accept) begin
                    acc_d = mac_sum;
                    cnt_d = cnt_q + CNT_W'(1);
`ifdef MAC_ACCUM_OVF_EN
                    sticky_d = sticky_q | mac_ovf;
`endif
                    if (cnt_q == LAST) begin
                        out_data_d  = mac_sum;
                        out_valid_d = 1'b1;
                        state_d     = ST_DONE;
`ifdef MAC_ACCUM_OVF_EN
                        out_ovf_d   = sticky_q | mac_ovf;
`endif
                    end
                end
            end
            ST_DONE: begin
                // acc_clr has no effect here; the result waits for its handshake
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    acc_d       = '0;
                    cnt_d       = '0;
                    state_d     = ST_ACCUM;
`ifdef MAC_ACCUM_OVF_EN
                    sticky_d    = 1'b0;
`endif
                end
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
`ifdef MAC_ACCUM_OVF_EN
            sticky_q    <= 1'b0;
            out_ovf_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
`ifdef MAC_ACCUM_OVF_EN
            sticky_q    <= sticky_d;
            out_ovf_q   <= out_ovf_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
`ifdef MAC_ACCUM_OVF_EN
    assign out_ovf   = out_ovf_q;
`endif

endmodule

// File: tb/tb_mac_accum_seq.sv
// Scoreboard bench for mac_accum_seq: frame results from a sum-of-products model.
module tb_mac_accum_seq;

    localparam int W = 4;
    localparam int N = 4;

    typedef struct {
        int unsigned data;
        bit          ovf;
    } res_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         acc_clr = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic         out_ovf;

    int n_pass  = 0;
    int n_total = 0;
    bit mon_en  = 0;
    bit m_done  = 0;

    res_t        sb[$];
    int unsigned prods[$];

    always #5 clk = ~clk;

    mac_accum_seq #(
        .WIDTH    (W),
        .NUM_TERMS(N)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .acc_clr  (acc_clr),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
`ifdef MAC_ACCUM_OVF_EN
        ,
        .out_ovf  (out_ovf)
`endif
    );

`ifndef MAC_ACCUM_OVF_EN
    assign out_ovf = 1'b0;
`endif

    task automatic check(string name, int act, int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Result monitor: every presented result must match the oldest expected frame
    always @(negedge clk) begin
        if (mon_en && out_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                check("out_data", int'(out_data), int'(sb[0].data));
`ifdef MAC_ACCUM_OVF_EN
                check("out_ovf", int'(out_ovf), int'(sb[0].ovf));
`endif
                if (out_ready) sb.pop_front();
            end
        end
    end

    task automatic cycle();
        int unsigned total;
        res_t r;
        @(negedge clk);
        check("in_ready", int'(in_ready), int'(!m_done && !acc_clr));
        check("out_valid", int'(out_valid), int'(m_done));
        #1;
        if (rst) begin
            if (m_done && !out_ready) sb.delete(sb.size() - 1);
            m_done = 0;
            prods.delete();
        end else if (m_done) begin
            if (out_ready) m_done = 0;
        end else if (acc_clr) begin
            prods.delete();
        end else if (in_valid) begin
            prods.push_back(int'(in_a) * int'(in_b));
            if (prods.size() == N) begin
                total = 0;
                foreach (prods[i]) total += prods[i];
                r.data = total % (1 << W);
                r.ovf  = (total >= (1 << W));
                sb.push_back(r);
                prods.delete();
                m_done = 1;
            end
        end
        @(posedge clk);
        #2;
    endtask

    task automatic drive(bit v, int a, int b, bit clr, bit ordy, bit r);
        in_valid  = v;
        in_a      = W'(a);
        in_b      = W'(b);
        acc_clr   = clr;
        out_ready = ordy;
        rst       = r;
        cycle();
    endtask

    task automatic send(int a, int b, bit ordy = 1);
        drive(1, a, b, 0, ordy, 0);
    endtask

    task automatic idle(int n, bit ordy = 1);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, ordy, 0);
    endtask

    initial begin
        int a1[4] = '{3, 2, 1, 0};
        int b1[4] = '{5, 2, 1, 7};

        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", int'(in_ready), 1);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_out_data", int'(out_data), 0);
        @(posedge clk);
        #2;
        mon_en = 1;

        // back-to-back frame, result 4 with overflow
        for (int i = 0; i < 4; i++) send(a1[i], b1[i]);
        idle(2);

        // overflowing frame then a clean frame
        for (int i = 0; i < 4; i++) send(15, 15);
        idle(2);
        for (int i = 0; i < 4; i++) send(1, 1);
        idle(2);

        // result held under backpressure
        for (int i = 0; i < 4; i++) send(i + 1, 3, 0);
        idle(5, 0);
        idle(3, 1);

        // abort with a simultaneous pair that must be dropped
        send(2, 3);
        drive(1, 7, 7, 1, 1, 0);
        for (int i = 0; i < 4; i++) send(1, 2);
        idle(2);

        // reset mid-frame, then a fresh frame
        send(5, 5);
        send(6, 6);
        drive(0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 4; i++) send(1, 1);
        idle(2);

        // reset while a result is pending discards it
        for (int i = 0; i < 4; i++) send(2, 2, 0);
        idle(1, 0);
        drive(0, 0, 0, 0, 0, 1);
        idle(2);

        // same pairs with random bubbles
        for (int i = 0; i < 4; i++) begin
            idle($urandom_range(0, 3));
            send(a1[i], b1[i]);
        end
        idle(2);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0,
                  $urandom_range(0, 15), $urandom_range(0, 15),
                  $urandom_range(0, 19) == 0,
                  $urandom_range(0, 2) != 0,
                  $urandom_range(0, 99) == 0);
        end
        idle(6);

        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
